key_event_queue: RTL and testbench
==================================

// Module: key_event_queue
// PURPOSE
//  Sits between the PS/2 keyboard decoder and the two-digit key-in FSM.
//  Turns raw keyboard state (key_down, last_change, key_valid) into one
//  synchronous code per key press. Filters typematic repeats and buffers
//  codes in a small FIFO. Output uses a valid/ready handshake, so consumers
//  never clock on key_down bits.
// PARAMETERS
//  FIFO_DEPTH    4  queue entries; power of two, >= 2
//  DROP_INVALID  1  1: unmapped keys are discarded; 0: enqueued as code 11
//  REPEAT_FILTER 1  1: suppress repeated makes of a held key
// PORTS
//  clk          in   1    system clock; single clock domain
//  rst          in   1    asynchronous, active-high reset
//  key_valid    in   1    1-cycle pulse from decoder: last_change updated
//  last_change  in   9    scancode of last event; bit 8 = E0-extended
//  key_down     in   512  per-scancode held state from decoder
//  digit        out  4    head-of-queue code
//  digit_valid  out  1    digit is valid
//  digit_ready  in   1    consumer accepts digit when valid && ready
//  overflow     out  1    sticky: a press was dropped because the queue was full
//  ovf_clr      in   1    clears overflow (synchronous)
// BEHAVIOUR
//  Reset (async, rst=1):
//   - digit=0, digit_valid=0, overflow=0
//   - FIFO empty; pipeline register cleared; held flag cleared
//  Stage 0 (cycle N, key_valid=1):
//   - make  = key_down[last_change]=1
//   - break = key_down[last_change]=0
//   - code map, main row and keypad:
//       0x45/0x70->0, 0x16/0x69->1, 0x1E/0x72->2, 0x26/0x7A->3,
//       0x25/0x6B->4, 0x2E/0x73->5, 0x36/0x74->6, 0x3D/0x6C->7,
//       0x3E/0x75->8, 0x46/0x7D->9
//       0x05A/0x15A (Enter)->15; anything else->11
//  Stage 1 (registered at end of N):
//   - evt_stb, evt_make, evt_code, evt_scan
//  Repeat filter (REPEAT_FILTER=1):
//   - accepted make sets held=1, held_scan=scan
//   - make with held && scan==held_scan is dropped
//   - break of held_scan clears held
//   - make of a different key is accepted and replaces held_scan
//   - breaks are never enqueued
//  Push: evt_stb && evt_make && not filtered && !(code==11 && DROP_INVALID)
//   - written at end of N+1; digit_valid=1 in N+2 if the queue was empty
//   - total latency: 2 cycles
//  Pop: digit_valid && digit_ready; the next entry shows the cycle after
//  Full:
//   - push with no pop is dropped; overflow<=1
//   - push and pop in the same cycle while full: both happen
//  Empty: digit_valid=0; digit holds its last value (don't-care)
//  Overflow register:
//   - ovf_clr and a new overflow in the same cycle: overflow stays 1
//  Reset mid-operation: queued codes and held state are discarded
//  Pointers: log2(FIFO_DEPTH) bits, wrap modulo depth
//   - count is one bit wider; full = count==FIFO_DEPTH
// STRUCTURE
//  Shared header key_codes.vh:
//   - `CODE_ENTER 15, `CODE_INVALID 11, `DIGIT_W 4
//   - scancode `defines used by the map
//  Map is a combinational case in this module.
//  Sub-module key_fifo: sync FIFO (WIDTH, DEPTH), ports clk/rst/push/pop/
//  din/dout/empty/full.
//  This module contains stage register, filter, map, overflow logic.
// TESTING
//  - Single press: key_valid, 0x16 make -> digit=1, digit_valid=1 exactly
//    2 cycles later; pop with ready=1 -> digit_valid=0 next cycle.
//  - Typematic: three makes of 0x1E, no break -> one entry (2).
//    Then break, then make -> second entry (2).
//  - Enter and keypad: 0x15A make -> 15; 0x7D make -> 9;
//    0x1C ('A') make with DROP_INVALID=1 -> no entry; with 0 -> 11.
//  - Overflow: ready=0, five distinct digit presses 1..5 -> queue 1,2,3,4;
//    overflow=1. ovf_clr -> overflow=0. Drain order 1,2,3,4.
//  - Full plus simultaneous push/pop: full queue, ready=1 on the same cycle
//    as a push of 7 -> 1 popped, 7 enqueued, overflow stays 0.
//  - Async reset: rst pulse mid-queue (between clock edges) -> digit_valid=0
//    immediately; held cleared, so the next make of the same key is accepted.

Source files
------------

// File: rtl/key_event_queue_pkg.sv
// Shared codes and scancodes for the keyboard event queue.
package key_event_queue_pkg;

    localparam int DIGIT_W = 4;
    localparam int SCAN_W  = 9;

    typedef logic [DIGIT_W-1:0] digit_t;
    typedef logic [SCAN_W-1:0]  scan_t;

    localparam digit_t CODE_ENTER   = 4'd15;
    localparam digit_t CODE_INVALID = 4'd11;

    // Main-row digit scancodes
    localparam scan_t SC_MAIN_0 = 9'h045;
    localparam scan_t SC_MAIN_1 = 9'h016;
    localparam scan_t SC_MAIN_2 = 9'h01E;
    localparam scan_t SC_MAIN_3 = 9'h026;
    localparam scan_t SC_MAIN_4 = 9'h025;
    localparam scan_t SC_MAIN_5 = 9'h02E;
    localparam scan_t SC_MAIN_6 = 9'h036;
    localparam scan_t SC_MAIN_7 = 9'h03D;
    localparam scan_t SC_MAIN_8 = 9'h03E;
    localparam scan_t SC_MAIN_9 = 9'h046;

    // Keypad digit scancodes
    localparam scan_t SC_PAD_0 = 9'h070;
    localparam scan_t SC_PAD_1 = 9'h069;
    localparam scan_t SC_PAD_2 = 9'h072;
    localparam scan_t SC_PAD_3 = 9'h07A;
    localparam scan_t SC_PAD_4 = 9'h06B;
    localparam scan_t SC_PAD_5 = 9'h073;
    localparam scan_t SC_PAD_6 = 9'h074;
    localparam scan_t SC_PAD_7 = 9'h06C;
    localparam scan_t SC_PAD_8 = 9'h075;
    localparam scan_t SC_PAD_9 = 9'h07D;

    // Enter on the main block and the E0-extended keypad Enter
    localparam scan_t SC_ENTER_MAIN = 9'h05A;
    localparam scan_t SC_ENTER_PAD  = 9'h15A;

endpackage

// File: rtl/key_event_queue_fifo.sv
// Small synchronous FIFO with combinational read of the head entry.
module key_event_queue_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign dout  = mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when the head leaves in the same cycle
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer and occupancy next-state; pointers wrap modulo DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage and pointers; storage is cleared so the head reads 0 out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= din;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// Converts raw PS/2 decoder state into one queued digit code per key press,
// with typematic-repeat filtering and a valid/ready output.
module key_event_queue
    import key_event_queue_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter bit DROP_INVALID  = 1'b1,
    parameter bit REPEAT_FILTER = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_valid,
    input  logic [SCAN_W-1:0]  last_change,
    input  logic [511:0]       key_down,
    output logic [DIGIT_W-1:0] digit,
    output logic               digit_valid,
    input  logic               digit_ready,
    output logic               overflow,
    input  logic               ovf_clr
);

    digit_t code_s0;

    logic   evt_stb_q;
    logic   evt_make_q;
    digit_t evt_code_q;
    scan_t  evt_scan_q;

    logic   held_q, held_d;
    scan_t  held_scan_q, held_scan_d;
    logic   overflow_q, overflow_d;

    logic   repeat_hit, accept_make, push_req, pop_acc, ovf_set;
    logic   fifo_empty, fifo_full;

    // Scancode to digit code; extended codes other than keypad Enter are unmapped
    always_comb begin
        code_s0 = CODE_INVALID;
        case (last_change)
            SC_MAIN_0, SC_PAD_0:          code_s0 = 4'd0;
            SC_MAIN_1, SC_PAD_1:          code_s0 = 4'd1;
            SC_MAIN_2, SC_PAD_2:          code_s0 = 4'd2;
            SC_MAIN_3, SC_PAD_3:          code_s0 = 4'd3;
            SC_MAIN_4, SC_PAD_4:          code_s0 = 4'd4;
            SC_MAIN_5, SC_PAD_5:          code_s0 = 4'd5;
            SC_MAIN_6, SC_PAD_6:          code_s0 = 4'd6;
            SC_MAIN_7, SC_PAD_7:          code_s0 = 4'd7;
            SC_MAIN_8, SC_PAD_8:          code_s0 = 4'd8;
            SC_MAIN_9, SC_PAD_9:          code_s0 = 4'd9;
            SC_ENTER_MAIN, SC_ENTER_PAD:  code_s0 = CODE_ENTER;
            default:                      code_s0 = CODE_INVALID;
        endcase
    end

    // Event stage register: captures make/break, code and scan on each decoder pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_stb_q  <= 1'b0;
            evt_make_q <= 1'b0;
            evt_code_q <= '0;
            evt_scan_q <= '0;
        end else begin
            evt_stb_q <= key_valid;
            if (key_valid) begin
                evt_make_q <= key_down[last_change];
                evt_code_q <= code_s0;
                evt_scan_q <= last_change;
            end
        end
    end

    // A make of the key already held is a typematic repeat and is dropped
    assign repeat_hit  = REPEAT_FILTER && held_q && (evt_scan_q == held_scan_q);
    assign accept_make = evt_stb_q && evt_make_q && !repeat_hit;
    assign push_req    = accept_make && !(DROP_INVALID && (evt_code_q == CODE_INVALID));
    assign pop_acc     = digit_valid && digit_ready;
    assign ovf_set     = push_req && fifo_full && !pop_acc;

    // Held-key tracking: accepted makes take ownership, break of the held key releases it
    always_comb begin
        held_d      = held_q;
        held_scan_d = held_scan_q;
        if (REPEAT_FILTER) begin
            if (accept_make) begin
                held_d      = 1'b1;
                held_scan_d = evt_scan_q;
            end else if (evt_stb_q && !evt_make_q && held_q && (evt_scan_q == held_scan_q)) begin
                held_d = 1'b0;
            end
        end
    end

    // Overflow is sticky; a new drop wins over a clear in the same cycle
    always_comb begin
        overflow_d = ovf_set | (overflow_q & ~ovf_clr);
    end

    // Filter and overflow state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q      <= 1'b0;
            held_scan_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            held_q      <= held_d;
            held_scan_q <= held_scan_d;
            overflow_q  <= overflow_d;
        end
    end

    key_event_queue_fifo #(
        .WIDTH (DIGIT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop_acc),
        .din   (evt_code_q),
        .dout  (digit),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign digit_valid = !fifo_empty;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue: latency, repeat filter, mapping,
// overflow, full-with-pop and asynchronous reset.
module tb_key_event_queue;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [8:0]   last_change;
    logic [511:0] key_down;
    logic [3:0]   digit;
    logic         digit_valid;
    logic         digit_ready;
    logic         overflow;
    logic         ovf_clr;

    logic [3:0]   digit_k;
    logic         digit_valid_k;
    logic         overflow_k;
    logic         digit_ready_k;

    int checks = 0;
    int errors = 0;

    key_event_queue #(.FIFO_DEPTH(4), .DROP_INVALID(1'b1), .REPEAT_FILTER(1'b1)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
        .key_down(key_down), .digit(digit), .digit_valid(digit_valid),
        .digit_ready(digit_ready), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    // Second instance keeps unmapped keys; its consumer is always ready
    key_event_queue #(.FIFO_DEPTH(4), .DROP_INVALID(1'b0), .REPEAT_FILTER(1'b1)) dut_keep (
        .clk(clk), .rst(rst), .key_valid(key_valid), .last_change(last_change),
        .key_down(key_down), .digit(digit_k), .digit_valid(digit_valid_k),
        .digit_ready(digit_ready_k), .overflow(overflow_k), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic key_evt(input logic [8:0] sc, input logic down);
        key_down[sc] = down;
        last_change  = sc;
        key_valid    = 1'b1;
        tick();
        key_valid    = 1'b0;
    endtask

    task automatic pop();
        digit_ready = 1'b1;
        tick();
        digit_ready = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        key_valid     = 1'b0;
        last_change   = '0;
        key_down      = '0;
        digit_ready   = 1'b0;
        digit_ready_k = 1'b1;
        ovf_clr       = 1'b0;
        tick();
        tick();
        chk("reset_valid", digit_valid, 0);
        chk("reset_digit", digit, 0);
        chk("reset_overflow", overflow, 0);
        rst = 1'b0;
        tick();

        // Single press: two-cycle latency, pop empties the queue
        key_evt(9'h016, 1'b1);
        chk("single_valid_n1", digit_valid, 0);
        tick();
        chk("single_valid_n2", digit_valid, 1);
        chk("single_digit", digit, 1);
        pop();
        chk("single_after_pop", digit_valid, 0);
        key_evt(9'h016, 1'b0);
        tick();

        // Typematic: three makes without break give one entry
        key_evt(9'h01E, 1'b1);
        key_evt(9'h01E, 1'b1);
        key_evt(9'h01E, 1'b1);
        tick();
        chk("typematic_valid", digit_valid, 1);
        chk("typematic_digit", digit, 2);
        pop();
        chk("typematic_one_entry", digit_valid, 0);
        key_evt(9'h01E, 1'b0);
        key_evt(9'h01E, 1'b1);
        tick();
        chk("repress_valid", digit_valid, 1);
        chk("repress_digit", digit, 2);
        pop();
        chk("repress_empty", digit_valid, 0);

        // Keypad Enter, keypad 9, unmapped 'A'
        key_evt(9'h15A, 1'b1);
        tick();
        chk("enter_digit", digit, 15);
        pop();
        key_evt(9'h07D, 1'b1);
        tick();
        chk("pad9_digit", digit, 9);
        pop();
        key_evt(9'h01C, 1'b1);
        tick();
        chk("invalid_dropped", digit_valid, 0);
        chk("invalid_kept_valid", digit_valid_k, 1);
        chk("invalid_kept_digit", digit_k, 11);

        // Overflow: five presses into a four-entry queue
        key_evt(9'h016, 1'b1);
        key_evt(9'h01E, 1'b1);
        key_evt(9'h026, 1'b1);
        key_evt(9'h025, 1'b1);
        key_evt(9'h02E, 1'b1);
        chk("ovf_before_drop", overflow, 0);
        key_evt(9'h036, 1'b1);
        chk("ovf_set", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_set_beats_clr", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain_valid_%0d", i), digit_valid, 1);
            chk($sformatf("drain_digit_%0d", i), digit, i);
            pop();
        end
        chk("drain_empty", digit_valid, 0);

        // Full queue with a push and pop in the same cycle
        key_evt(9'h016, 1'b1);
        key_evt(9'h01E, 1'b1);
        key_evt(9'h026, 1'b1);
        key_evt(9'h025, 1'b1);
        key_evt(9'h03D, 1'b1);
        digit_ready = 1'b1;
        tick();
        digit_ready = 1'b0;
        chk("fullpop_overflow", overflow, 0);
        chk("fullpop_head", digit, 2);
        chk("fullpop_next3", digit, 2);
        pop();
        chk("fullpop_3", digit, 3);
        pop();
        chk("fullpop_4", digit, 4);
        pop();
        chk("fullpop_7", digit, 7);
        pop();
        chk("fullpop_empty", digit_valid, 0);

        // Asynchronous reset between edges discards queue and held key
        key_evt(9'h036, 1'b1);
        tick();
        chk("pre_reset_digit", digit, 6);
        key_evt(9'h03E, 1'b1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", digit_valid, 0);
        chk("async_digit", digit, 0);
        chk("async_overflow", overflow, 0);
        #1;
        rst = 1'b0;
        key_evt(9'h036, 1'b1);
        tick();
        chk("post_reset_valid", digit_valid, 1);
        chk("post_reset_digit", digit, 6);
        pop();
        chk("post_reset_empty", digit_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
